// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and scan state type for the display scanner
package display_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef enum logic {BLANK, ON} scan_state_t;
endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - hex nibble to active-low {a..g} segment decoder
module hex_to_7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (hex_i)
      4'h0:    seg_o = 7'b0000001;
      4'h1:    seg_o = 7'b1001111;
      4'h2:    seg_o = 7'b0010010;
      4'h3:    seg_o = 7'b0000110;
      4'h4:    seg_o = 7'b1001100;
      4'h5:    seg_o = 7'b0100100;
      4'h6:    seg_o = 7'b0100000;
      4'h7:    seg_o = 7'b0001111;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0000100;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b1100000;
      4'hC:    seg_o = 7'b1110010;
      4'hD:    seg_o = 7'b1000010;
      4'hE:    seg_o = 7'b0110000;
      default: seg_o = 7'b0111000;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit 7-segment scan controller with per-slot blanking
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int            CW            = $clog2(TICK_DIV);
  localparam int            DW            = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST      = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST      = DW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dig_q, dig_d;
  scan_state_t   state_q, state_d;
  logic [15:0]   sh_value_q;
  logic [3:0]    sh_en_q, sh_dp_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q;

  logic       slot_end, frame_end;
  logic [6:0] dec_seg;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (dig_q == DIG_LAST);

  hex_to_7seg u_dec (
    .hex_i (sh_value_q[{dig_q, 2'b00} +: 4]),
    .seg_o (dec_seg)
  );

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + CW'(1);
    dig_d   = slot_end ? dig_q + DW'(1) : dig_q;
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_q == CNT_BLANK_END) state_d = ON;
      default: if (slot_end) state_d = BLANK;
    endcase
  end

  // A masked digit still occupies its slot but stays dark, keeping duty cycle constant.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_q == ON && sh_en_q[dig_q]) begin
      an_d[dig_q] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~sh_dp_q[dig_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      state_q      <= BLANK;
      sh_value_q   <= '0;
      sh_en_q      <= '0;
      sh_dp_q      <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      state_q      <= state_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_end;
      if (frame_end) begin
        sh_value_q <= value;
        sh_en_q    <= digit_en;
        sh_dp_q    <= dp_in;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - table-driven self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;
  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * TD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      en;
    logic [3:0]      dpin;
    int              apply_j;
    logic [3:0][6:0] seg;
  } vec_t;

  vec_t tbl[7];

  display_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_dark(input string tag, input logic exp_fd);
    chk({tag, " an"}, 32'(an), 32'hF);
    chk({tag, " seg"}, 32'(seg), 32'h7F);
    chk({tag, " dp"}, 32'(dp), 32'h1);
    chk({tag, " frame_done"}, 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic apply(input int i);
    value    = tbl[i].value;
    digit_en = tbl[i].en;
    dp_in    = tbl[i].dpin;
  endtask

  // Output cycle j=1..32 after a frame_done pulse: slot (j-1)/8, lit when in-slot cycle >= BC+1.
  task automatic check_frame(input int i, input int nxt);
    for (int j = 1; j <= FRAME; j++) begin
      int d;
      int c;
      logic lit;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic e_dp;
      @(negedge clk);
      d     = (j - 1) / TD;
      c     = (j - 1) % TD + 1;
      lit   = (c >= BC + 1) && tbl[i].en[d];
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (lit) begin
        e_an[d] = 1'b0;
        e_seg   = tbl[i].seg[d];
        e_dp    = ~tbl[i].dpin[d];
      end
      chk($sformatf("v%0d j%0d an", i, j), 32'(an), 32'(e_an));
      chk($sformatf("v%0d j%0d seg", i, j), 32'(seg), 32'(e_seg));
      chk($sformatf("v%0d j%0d dp", i, j), 32'(dp), 32'(e_dp));
      chk($sformatf("v%0d j%0d frame_done", i, j), 32'(frame_done), 32'(j == FRAME));
      if (nxt >= 0 && j == tbl[nxt].apply_j) apply(nxt);
    end
  endtask

  initial begin
    tbl[0] = '{16'h0000, 4'hF, 4'h0, 1,  {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}};
    tbl[1] = '{16'h3210, 4'hF, 4'h0, 1,  {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001}};
    tbl[2] = '{16'hABCD, 4'hF, 4'h0, 1,  {7'b0001000, 7'b1100000, 7'b1110010, 7'b1000010}};
    tbl[3] = '{16'h1111, 4'hF, 4'h0, 1,  {7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111}};
    tbl[4] = '{16'h2222, 4'hF, 4'h0, 12, {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}};
    tbl[5] = '{16'h3210, 4'b0101, 4'b0100, 1, {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001}};
    tbl[6] = '{16'h8888, 4'hF, 4'hF, 5,  {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}};

    rst = 1'b1;
    apply(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_dark("in reset", 1'b0);
    rst = 1'b0;

    // First frame is dark regardless of inputs; pulse at output cycle 32.
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      chk_dark($sformatf("first frame k%0d", k), k == FRAME);
    end

    for (int i = 0; i < 7; i++) check_frame(i, (i < 6) ? i + 1 : -1);

    // Reset during slot 2 ON phase: immediate blanking, shadows cleared, fresh frame timing.
    repeat (20) @(negedge clk);
    chk("pre-reset slot2 an", 32'(an), 32'hB);
    rst = 1'b1;
    @(negedge clk);
    chk_dark("mid-slot reset", 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      chk_dark($sformatf("post-reset k%0d", k), k == FRAME);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
